im_fetch_responder: RTL
=======================

# im_fetch_responder

Instruction-memory responder at the far end of the fetch interface. The PC stage presents fetch addresses through a valid/ready request channel. This block reads the instruction ROM and returns the instruction word, its PC and a fault flag through a valid/ready response channel, backed by a 2-entry output buffer. It sits between the PC/next-PC logic and the IF/ID pipeline register, and supports back-to-back fetches, back-pressure and pipeline flush.

## Interface
Parameters:
- BASE_ADDR, 32'h00003000, byte address of ROM word 0; matches the PC reset value.
- DEPTH_WORDS, 1024, number of 32-bit ROM words; power of two.
- INIT_FILE, "code.txt", hex image loaded into the ROM at elaboration.

Ports:
- Clk  in  1  sole clock; all state updates on posedge.
- Reset_n  in  1  synchronous, active-low reset.
- Req_Valid  in  1  the PC stage presents a fetch address.
- Req_Addr  in  32  byte address of the fetch.
- Req_Ready  out  1  the block can accept the request this cycle.
- Rsp_Valid  out  1  the head of the output buffer holds a response.
- Rsp_Ready  in  1  the consumer (IF/ID) takes the response this cycle.
- Rsp_Instr  out  32  instruction word; 32'h0 on fault.
- Rsp_PC  out  32  Req_Addr of the request that produced this response.
- Rsp_Fault  out  1  the address was misaligned or outside the ROM.
- Flush  in  1  discards all in-flight and buffered fetches (branch/jump redirect).

## Operation
- A request is accepted when Req_Valid & Req_Ready are high at a posedge.
- A response is popped when Rsp_Valid & Rsp_Ready are high at a posedge.
- Two-stage datapath:
  - Stage R (read) holds one in-flight entry: valid bit, PC, fault bit, and the synchronous ROM read data.
  - The output buffer is a 2-entry FIFO (count 0..2, 1-bit read and write pointers with wrap).
- Fault check is done at acceptance:
  - fault = (Req_Addr[1:0] != 0) | (Req_Addr < BASE_ADDR) | (Req_Addr >= BASE_ADDR + 4*DEPTH_WORDS).
  - The comparison uses 33-bit arithmetic, so BASE_ADDR + 4*DEPTH_WORDS never wraps.
- ROM index = (Req_Addr - BASE_ADDR)[log2(DEPTH_WORDS)+1:2]. On fault the ROM is not read and the stored instruction is 32'h0.
- Occupancy = count + R.valid.
- Req_Ready = !Flush & Reset_n & ((occupancy < 2) | (Rsp_Valid & Rsp_Ready)). This is a combinational pass-through of Rsp_Ready, which gives full throughput.
- Each posedge, in priority order:
  1. Reset_n low: all valid bits, count and pointers cleared; all data registers set to 0.
  2. Flush high: R.valid cleared, count and pointers cleared. Any request or pop in the same cycle is ignored; no Rsp_Ready handshake takes effect.
  3. Otherwise:
     - If R.valid, push R into the FIFO.
     - R is loaded from the accepted request, else R.valid is cleared.
     - A pop and a push in the same cycle leave count unchanged.
- Rsp_Valid = (count != 0). Rsp_Instr, Rsp_PC and Rsp_Fault are driven from the FIFO head entry.
- Responses return strictly in request order.
- Push into a full FIFO cannot occur by construction of Req_Ready. The bench asserts this.

## Timing
- Latency: a request accepted at edge k appears at the FIFO head after edge k+1 (Rsp_Valid high in the cycle following edge k+1), provided the FIFO was empty.
- Throughput: one fetch per cycle while Rsp_Ready is held high.
- With Rsp_Ready low: at most 2 accepted fetches are outstanding (1 in R plus 1 in the FIFO, or 2 in the FIFO). Req_Ready then drops until a pop.
- Reset: during Reset_n low and in the cycle after, Rsp_Valid=0, Rsp_Instr=0, Rsp_PC=0, Rsp_Fault=0. Req_Ready=0 while Reset_n is low and 1 from the first cycle after reset is released.
- Reset or Flush mid-operation: all pending responses are lost with no partial output. Rsp_Valid=0 in the cycle after the edge. Req_Ready is 1 in that cycle.
- Response outputs are stable while Rsp_Valid & !Rsp_Ready, and Rsp_Valid is not withdrawn except by Flush or reset.

## Test plan
- Reset then single fetch: Req_Addr=0x3000 accepted at edge k → after edge k+1, Rsp_Valid=1, Rsp_PC=0x3000, Rsp_Instr=ROM[0], Rsp_Fault=0.
- Streaming: Rsp_Ready=1, addresses 0x3000, 0x3004, … 0x301C on consecutive cycles → 8 responses on 8 consecutive cycles, in order, with Req_Ready never low.
- Back-pressure: Rsp_Ready=0, issue 0x3000, 0x3004, 0x3008 → the first two are accepted and Req_Ready=0 on the third. Raise Rsp_Ready → 0x3000 and 0x3004 pop in order, then 0x3008 is accepted.
- Faults: 0x3002, 0x2FFC and 0x3000+4*DEPTH_WORDS → Rsp_Fault=1 and Rsp_Instr=0 for each; a following 0x3004 returns ROM[1] with Rsp_Fault=0.
- Flush: with 2 outstanding fetches, pulse Flush for one cycle (Req_Valid=1 in that cycle) → no response is produced for the old or the flush-cycle request. Rsp_Valid=0 on the next cycle, Req_Ready=1, and the next request 0x3040 returns normally.
- Reset mid-stream: drop Reset_n for one cycle with the FIFO full → all outputs are 0 afterwards and no stale response appears.

Source files
------------

// File: rtl/im_fetch_responder.sv
// rtl/im_fetch_responder.sv - instruction ROM fetch responder with 2-entry response buffer
//
// Purpose:
//   Accepts fetch addresses from the PC stage, reads the instruction ROM
//   through a one-entry read stage (R) and returns {instruction, PC, fault}
//   through a 2-entry output FIFO. Requests are answered strictly in order,
//   one per cycle when the consumer keeps up. Flush discards everything
//   in flight.
//
// Parameters:
//   BASE_ADDR    byte address of ROM word 0
//   DEPTH_WORDS  number of 32-bit ROM words (power of two)
//   INIT_FILE    image name; the ROM holds a built-in ramp image
//                (word i = 32'hC0DE_0000 | i)
//
// Ports:
//   Clk        in   sole clock, rising edge
//   Reset_n    in   synchronous active-low reset
//   Req_Valid  in   fetch address presented
//   Req_Addr   in   [31:0] fetch byte address
//   Req_Ready  out  request accepted this cycle if Req_Valid
//   Rsp_Valid  out  FIFO head holds a response
//   Rsp_Ready  in   consumer takes the head this cycle
//   Rsp_Instr  out  [31:0] instruction word (0 on fault)
//   Rsp_PC     out  [31:0] address of the request behind this response
//   Rsp_Fault  out  address misaligned or outside the ROM
//   Flush      in   drop all in-flight and buffered fetches

module im_fetch_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_3000,
    parameter int          DEPTH_WORDS = 1024,
    parameter string       INIT_FILE   = "code.txt"
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Req_Valid,
    input  logic [31:0] Req_Addr,
    output logic        Req_Ready,
    output logic        Rsp_Valid,
    input  logic        Rsp_Ready,
    output logic [31:0] Rsp_Instr,
    output logic [31:0] Rsp_PC,
    output logic        Rsp_Fault,
    input  logic        Flush
);

    localparam int AW = $clog2(DEPTH_WORDS);

    // Bounds are held in 33 bits so BASE_ADDR + ROM size cannot wrap.
    localparam logic [32:0] ROM_LO = {1'b0, BASE_ADDR};
    localparam logic [32:0] ROM_HI = ROM_LO + (33'(DEPTH_WORDS) << 2);

    // ------------------------------------------------------------------
    // Instruction ROM
    // ------------------------------------------------------------------
    logic [31:0] rom [DEPTH_WORDS];

    initial begin
        for (int i = 0; i < DEPTH_WORDS; i++) begin
            rom[i] = 32'hC0DE_0000 | 32'(i);
        end
    end

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic [32:0]   req_addr_ext;
    logic          req_fault;
    logic [31:0]   req_offset;
    logic [AW-1:0] req_index;
    logic          unused_offset_bits;

    assign req_addr_ext = {1'b0, Req_Addr};
    assign req_fault    = (Req_Addr[1:0] != 2'b00)
                        | (req_addr_ext < ROM_LO)
                        | (req_addr_ext >= ROM_HI);
    assign req_offset   = Req_Addr - BASE_ADDR;
    assign req_index    = req_offset[AW+1:2];
    // Only the word-index field of the offset addresses the ROM.
    assign unused_offset_bits = ^{req_offset[31:AW+2], req_offset[1:0]};

    // ------------------------------------------------------------------
    // State: read stage R and the 2-entry output FIFO
    // ------------------------------------------------------------------
    logic        r_valid;
    logic [31:0] r_pc;
    logic        r_fault;
    logic [31:0] r_instr;

    logic [31:0] fifo_instr [2];
    logic [31:0] fifo_pc    [2];
    logic        fifo_fault [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;

    logic [1:0]  occupancy;
    logic        accept;
    logic        pop;
    logic        push;

    assign Rsp_Valid = (count != 2'd0);
    assign pop       = Rsp_Valid & Rsp_Ready;
    assign push      = r_valid;
    assign occupancy = count + {1'b0, r_valid};

    // A pop in the same cycle frees a slot, so Rsp_Ready passes straight
    // through to Req_Ready; this is what sustains one fetch per cycle.
    assign Req_Ready = !Flush & Reset_n & ((occupancy < 2'd2) | pop);
    assign accept    = Req_Valid & Req_Ready;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_valid       <= 1'b0;
            r_pc          <= 32'h0;
            r_fault       <= 1'b0;
            r_instr       <= 32'h0;
            fifo_instr[0] <= 32'h0;
            fifo_instr[1] <= 32'h0;
            fifo_pc[0]    <= 32'h0;
            fifo_pc[1]    <= 32'h0;
            fifo_fault[0] <= 1'b0;
            fifo_fault[1] <= 1'b0;
            wr_ptr        <= 1'b0;
            rd_ptr        <= 1'b0;
            count         <= 2'd0;
        end else if (Flush) begin
            // Data registers keep stale contents; the cleared valid/count
            // state and the output masking keep them invisible.
            r_valid <= 1'b0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= 2'd0;
        end else begin
            // R always drains into the FIFO; Req_Ready guarantees room.
            if (push) begin
                fifo_instr[wr_ptr] <= r_instr;
                fifo_pc[wr_ptr]    <= r_pc;
                fifo_fault[wr_ptr] <= r_fault;
                wr_ptr             <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase

            r_valid <= accept;
            if (accept) begin
                r_pc    <= Req_Addr;
                r_fault <= req_fault;
                // Faulting fetches never touch the ROM.
                r_instr <= req_fault ? 32'h0 : rom[req_index];
            end
        end
    end

    // Head entry is masked so an empty buffer never shows stale data,
    // e.g. leftovers behind a flush.
    assign Rsp_Instr = Rsp_Valid ? fifo_instr[rd_ptr] : 32'h0;
    assign Rsp_PC    = Rsp_Valid ? fifo_pc[rd_ptr]    : 32'h0;
    assign Rsp_Fault = Rsp_Valid & fifo_fault[rd_ptr];

endmodule
